pbs_ctrl: RTL and testbench

Battle-sequencing controller that sits directly upstream of the battle datapath (pbs_dp). It drives every control input of the datapath and reads back both HP values. Each player confirm runs one full turn: the player attacks the AI, there is a display hold, the AI attacks the player, and there is a second hold. The controller then detects the winner and stays in the win state until reset.

---
 rtl/pbs_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pbs_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbs_ctrl.sv
// Battle-sequencing controller: runs one player/AI attack turn per confirm
// and drives the pbs_dp control inputs, then latches the winner.
module pbs_ctrl #(
  parameter int HOLD_CYCLES = 25000000,
  parameter int HOLD_W      = 25,
  parameter int TURN_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [1:0]        sw_move,
  input  logic [3:0]        p_hp,
  input  logic [3:0]        AI_hp,
  output logic [1:0]        p_move,
  output logic              actr,
  output logic              target,
  output logic              stop,
  output logic              load_ai_hp,
  output logic              app_ai_dmg,
  output logic              app_pl_dmg,
  output logic [TURN_W-1:0] turn_cnt,
  output logic [3:0]        state_out,
  output logic              p_win,
  output logic              ai_win,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    P_ROLL  = 4'd1,
    P_APPLY = 4'd2,
    P_CHECK = 4'd3,
    P_HOLD  = 4'd4,
    A_ROLL  = 4'd5,
    A_APPLY = 4'd6,
    A_CHECK = 4'd7,
    A_HOLD  = 4'd8,
    WIN_P   = 4'd9,
    WIN_AI  = 4'd10
  } state_t;

  // A zero hold length still spends one cycle in each HOLD state.
  localparam int HLAST_I = (HOLD_CYCLES <= 1) ? 0 : HOLD_CYCLES - 1;
  localparam logic [HOLD_W-1:0] HLAST = HLAST_I[HOLD_W-1:0];

  state_t            state, state_nx;
  logic              go_s1, go_s2, go_s3;
  logic              go_pulse;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              actr_nx, target_nx, stop_nx, load_nx;
  logic              app_ai_nx, app_pl_nx, p_win_nx, ai_win_nx, busy_nx;

  assign go_pulse  = go_s2 & ~go_s3;
  assign hold_done = (hold_cnt == HLAST);
  assign state_out = state;

  // go synchronizer and rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_s3 <= 1'b0;
    end else begin
      go_s1 <= go;
      go_s2 <= go_s1;
      go_s3 <= go_s2;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go_pulse) state_nx = P_ROLL;
      P_ROLL:  state_nx = P_APPLY;
      P_APPLY: state_nx = P_CHECK;
      P_CHECK: state_nx = (AI_hp == 4'd0) ? WIN_P : P_HOLD;
      P_HOLD:  if (hold_done) state_nx = A_ROLL;
      A_ROLL:  state_nx = A_APPLY;
      A_APPLY: state_nx = A_CHECK;
      A_CHECK: state_nx = (p_hp == 4'd0) ? WIN_AI : A_HOLD;
      A_HOLD:  if (hold_done) state_nx = IDLE;
      WIN_P:   state_nx = WIN_P;
      WIN_AI:  state_nx = WIN_AI;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_out.
  always_comb begin
    actr_nx   = actr;
    target_nx = target;
    stop_nx   = 1'b1;
    busy_nx   = 1'b1;
    load_nx   = (state_nx == P_ROLL);
    app_ai_nx = (state_nx == P_APPLY);
    app_pl_nx = (state_nx == A_APPLY);
    p_win_nx  = (state_nx == WIN_P);
    ai_win_nx = (state_nx == WIN_AI);
    case (state_nx)
      IDLE: begin
        actr_nx   = 1'b0;
        target_nx = 1'b0;
        stop_nx   = 1'b0;
        busy_nx   = 1'b0;
      end
      P_ROLL, P_APPLY, P_CHECK: begin
        actr_nx   = 1'b0;
        target_nx = 1'b1;
      end
      A_ROLL, A_APPLY, A_CHECK: begin
        actr_nx   = 1'b1;
        target_nx = 1'b0;
      end
      P_HOLD, A_HOLD: stop_nx = 1'b0;
      WIN_P, WIN_AI:  busy_nx = 1'b0;
      default: ;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      p_move     <= 2'd0;
      actr       <= 1'b0;
      target     <= 1'b0;
      stop       <= 1'b0;
      load_ai_hp <= 1'b0;
      app_ai_dmg <= 1'b0;
      app_pl_dmg <= 1'b0;
      p_win      <= 1'b0;
      ai_win     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        hold_cnt <= '0;
      end else if (state == P_HOLD || state == A_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == A_HOLD && hold_done && !(&turn_cnt)) begin
        turn_cnt <= turn_cnt + 1'b1;
      end
      if (state == IDLE && go_pulse) begin
        p_move <= sw_move;
      end
      actr       <= actr_nx;
      target     <= target_nx;
      stop       <= stop_nx;
      load_ai_hp <= load_nx;
      app_ai_dmg <= app_ai_nx;
      app_pl_dmg <= app_pl_nx;
      p_win      <= p_win_nx;
      ai_win     <= ai_win_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_pbs_ctrl.sv
// Bench for pbs_ctrl: directed turn scenarios plus random go/HP traffic,
// checked cycle by cycle against a schedule-based turn model.
module tb_pbs_ctrl;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [1:0] sw_move = 2'd0;
  logic [3:0] p_hp = 4'd15;
  logic [3:0] ai_hp = 4'd15;
  logic [1:0] p_move;
  logic       actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg;
  logic [1:0] turn_cnt;
  logic [3:0] state_out;
  logic       p_win, ai_win, busy;

  int n_chk = 0;
  int n_err = 0;
  int n_ai = 0;
  int n_pl = 0;

  // model: current state, the remaining turn schedule and go history
  int m_st;
  int mq[$];
  bit a1, a2, a3;
  int m_turn, m_pm, m_actr, m_tgt;

  pbs_ctrl #(.HOLD_CYCLES(H), .HOLD_W(3), .TURN_W(2)) dut (
    .clk(clk), .rst(rst), .go(go), .sw_move(sw_move), .p_hp(p_hp), .AI_hp(ai_hp),
    .p_move(p_move), .actr(actr), .target(target), .stop(stop),
    .load_ai_hp(load_ai_hp), .app_ai_dmg(app_ai_dmg), .app_pl_dmg(app_pl_dmg),
    .turn_cnt(turn_cnt), .state_out(state_out), .p_win(p_win), .ai_win(ai_win),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    mq.delete();
    a1 = 0; a2 = 0; a3 = 0;
    m_turn = 0; m_pm = 0; m_actr = 0; m_tgt = 0;
  endtask

  task automatic check_all();
    bit run_st, hold_st, win_st;
    run_st  = (m_st inside {1, 2, 3, 5, 6, 7});
    hold_st = (m_st == 4 || m_st == 8);
    win_st  = (m_st == 9 || m_st == 10);
    chk("state", int'(state_out), m_st);
    chk("p_move", int'(p_move), m_pm);
    chk("actr", int'(actr), m_actr);
    chk("target", int'(target), m_tgt);
    chk("stop", int'(stop), int'(run_st || win_st));
    chk("load_ai_hp", int'(load_ai_hp), int'(m_st == 1));
    chk("app_ai_dmg", int'(app_ai_dmg), int'(m_st == 2));
    chk("app_pl_dmg", int'(app_pl_dmg), int'(m_st == 6));
    chk("turn_cnt", int'(turn_cnt), m_turn);
    chk("p_win", int'(p_win), int'(m_st == 9));
    chk("ai_win", int'(ai_win), int'(m_st == 10));
    chk("busy", int'(busy), int'(run_st || hold_st));
  endtask

  // One clock: inputs seen at the edge feed the model, then everything is compared.
  task automatic step();
    bit g, pulse;
    int ai, ph, nxt;
    logic [1:0] sw;
    g = go; ai = ai_hp; ph = p_hp; sw = sw_move;
    @(posedge clk);
    #1;
    pulse = a2 && !a3;
    a3 = a2; a2 = a1; a1 = g;
    if (m_st == 0) begin
      nxt = 0;
      if (pulse) begin
        m_pm = sw;
        mq = {1, 2, 3};
        for (int i = 0; i < H; i++) mq.push_back(4);
        mq.push_back(5); mq.push_back(6); mq.push_back(7);
        for (int i = 0; i < H; i++) mq.push_back(8);
        mq.push_back(0);
        nxt = mq.pop_front();
      end
    end else if (m_st == 9 || m_st == 10) begin
      nxt = m_st;
    end else if (m_st == 3 && ai == 0) begin
      nxt = 9; mq.delete();
    end else if (m_st == 7 && ph == 0) begin
      nxt = 10; mq.delete();
    end else begin
      nxt = mq.pop_front();
    end
    if (m_st == 8 && nxt == 0 && m_turn < 3) m_turn++;
    m_st = nxt;
    if (m_st == 0) begin m_actr = 0; m_tgt = 0; end
    else if (m_st >= 1 && m_st <= 3) begin m_actr = 0; m_tgt = 1; end
    else if (m_st >= 5 && m_st <= 7) begin m_actr = 1; m_tgt = 0; end
    if (app_ai_dmg) n_ai++;
    if (app_pl_dmg) n_pl++;
    check_all();
  endtask

  task automatic run_until(input string tag, input int st, input int budget);
    int k;
    k = 0;
    while (m_st != st && k < budget) begin
      step();
      k++;
    end
    chk(tag, int'(state_out), st);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    p_hp = 4'd15;
    ai_hp = 4'd15;
    go = 1'b0;
  endtask

  task automatic start_turn(input logic [1:0] sw);
    sw_move = sw;
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
    chk("turn_start", int'(state_out), 1);
  endtask

  int exp_turns[4] = '{1, 2, 3, 3};

  initial begin
    model_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // full turn, sw_move changed mid-turn must not reach p_move
    n_ai = 0; n_pl = 0;
    start_turn(2'd2);
    sw_move = 2'd1;
    run_until("t1_idle", 0, 40);
    chk("t1_ai_pulses", n_ai, 1);
    chk("t1_pl_pulses", n_pl, 1);
    chk("t1_turns", int'(turn_cnt), 1);
    chk("t1_pmove", int'(p_move), 2);

    // player wins; later go pulses ignored
    do_reset();
    n_pl = 0;
    start_turn(2'd3);
    run_until("t2_pcheck", 3, 10);
    ai_hp = 4'd0;
    step();
    chk("t2_winp", int'(state_out), 9);
    for (int i = 0; i < 4; i++) begin
      go = 1'b1; step(); go = 1'b0;
      repeat (3) step();
    end
    chk("t2_pwin", int'(p_win), 1);
    chk("t2_no_pl_dmg", n_pl, 0);

    // AI wins, turn count stays 0
    do_reset();
    start_turn(2'd1);
    run_until("t3_acheck", 7, 20);
    p_hp = 4'd0;
    step();
    chk("t3_winai", int'(state_out), 10);
    chk("t3_turns", int'(turn_cnt), 0);

    // held go runs one turn; a go pulse during P_HOLD is not queued
    do_reset();
    sw_move = 2'd0;
    go = 1'b1;
    repeat (50) step();
    go = 1'b0;
    repeat (5) step();
    chk("t4_held_idle", int'(state_out), 0);
    chk("t4_held_turns", int'(turn_cnt), 1);
    start_turn(2'd2);
    run_until("t4_phold", 4, 10);
    go = 1'b1; step(); go = 1'b0;
    run_until("t4_idle", 0, 30);
    repeat (10) step();
    chk("t4_stay_idle", int'(state_out), 0);
    chk("t4_turns", int'(turn_cnt), 2);

    // asynchronous reset in A_HOLD takes effect before the next edge
    start_turn(2'd3);
    run_until("t5_ahold", 8, 20);
    #3 rst = 1'b0;
    #1;
    chk("t5_rst_state", int'(state_out), 0);
    chk("t5_rst_outs", int'({p_move, actr, target, stop, load_ai_hp, app_ai_dmg,
                             app_pl_dmg, p_win, ai_win, busy}), 0);
    chk("t5_rst_turns", int'(turn_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    start_turn(2'd1);
    run_until("t5_idle", 0, 30);

    // turn counter saturation
    do_reset();
    for (int t = 0; t < 4; t++) begin
      start_turn(2'(t));
      run_until("t6_idle", 0, 30);
      chk("t6_turns", int'(turn_cnt), exp_turns[t]);
    end

    // random traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      go = ($urandom_range(0, 7) == 0);
      sw_move = 2'($urandom_range(0, 3));
      ai_hp = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      p_hp = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step();
      if ((m_st == 9 || m_st == 10) && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
